// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues word fetches to instruction memory and
// buffers {pc, icode} pairs in a circular queue for the dispatch stage.
// Fetch issue is credit-limited so a returning response always finds a
// free slot; a redirect flushes the queue and restarts fetch at the target.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifq_pc,
  output logic [31:0] ifq_icode,
  output logic        ifq_empty,
  input  logic        dpch_rd,
  input  logic        dpch_jmp,
  input  logic [31:0] dpch_jmp_br_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMP_W = CNT_W + 1;

  logic [31:0]      fpc_q, fpc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [31:0]      mem_pc_q    [DEPTH];
  logic [31:0]      mem_pc_d    [DEPTH];
  logic [31:0]      mem_icode_q [DEPTH];
  logic [31:0]      mem_icode_d [DEPTH];

  logic             push;
  logic             pop;
  logic [CMP_W-1:0] credit_used;

  // Credits: stored entries plus an outstanding response must leave room.
  // Fetch is also suppressed while reset is held and in a redirect cycle.
  assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign imem_rd     = ~rst & ~dpch_jmp & (credit_used < CMP_W'(DEPTH));
  assign imem_addr   = fpc_q;

  // A redirect kills both the arriving response and any pop this cycle.
  assign push = inflight_q & ~dpch_jmp;
  assign pop  = dpch_rd & ~ifq_empty & ~dpch_jmp;

  assign ifq_empty = (count_q == '0);
  assign ifq_pc    = mem_pc_q[head_q];
  assign ifq_icode = mem_icode_q[head_q];

  // Next-state logic for fetch PC, pointers, occupancy and entry storage.
  always_comb begin
    fpc_d       = fpc_q;
    req_pc_d    = req_pc_q;
    inflight_d  = imem_rd;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    mem_pc_d    = mem_pc_q;
    mem_icode_d = mem_icode_q;

    if (imem_rd) begin
      fpc_d    = fpc_q + 32'd4;
      req_pc_d = fpc_q;
    end

    if (push) begin
      mem_pc_d[tail_q]    = req_pc_q;
      mem_icode_d[tail_q] = imem_data;
      tail_d              = tail_q + PTR_W'(1);
    end

    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (dpch_jmp) begin
      fpc_d   = dpch_jmp_br_addr;
      count_d = '0;
      head_d  = tail_q;
    end
  end

  // State registers; reset clears everything including stored entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_icode_q[i] <= '0;
      end
    end else begin
      fpc_q       <= fpc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      mem_pc_q    <= mem_pc_d;
      mem_icode_q <= mem_icode_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: directed stimulus with scoreboards for
// memory requests and dispatched instructions (memory returns addr as data).
module tb_inst_fetch_queue;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk;
  logic        rst;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifq_pc;
  logic [31:0] ifq_icode;
  logic        ifq_empty;
  logic        dpch_rd;
  logic        dpch_jmp;
  logic [31:0] dpch_jmp_br_addr;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_dlv[$];
  logic [31:0] e_req;
  logic [31:0] e_dlv;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_rd          (imem_rd),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .ifq_pc           (ifq_pc),
    .ifq_icode        (ifq_icode),
    .ifq_empty        (ifq_empty),
    .dpch_rd          (dpch_rd),
    .dpch_jmp         (dpch_jmp),
    .dpch_jmp_br_addr (dpch_jmp_br_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: one-cycle latency, data equals address.
  always @(posedge clk) begin
    imem_data <= imem_rd ? imem_addr : 32'hFFFF_FFFF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Request monitor: every fetch issued must match the next expected address.
  always @(negedge clk) begin
    if (imem_rd === 1'b1) begin
      if (exp_req.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_req: got=%h expected=none", imem_addr);
      end else begin
        e_req = exp_req.pop_front();
        chk("req_addr", imem_addr, e_req);
      end
    end
  end

  // Delivery monitor: every head entry consumed by dispatch is checked.
  always @(negedge clk) begin
    if (rst === 1'b0 && dpch_rd === 1'b1 && dpch_jmp === 1'b0 && ifq_empty === 1'b0) begin
      if (exp_dlv.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_dlv: got=%h expected=none", ifq_pc);
      end else begin
        e_dlv = exp_dlv.pop_front();
        chk("dlv_pc", ifq_pc, e_dlv);
        chk("dlv_icode", ifq_icode, e_dlv);
      end
    end
  end

  task automatic drive(input logic r, input logic rd, input logic jmp, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    rst              = r;
    dpch_rd          = rd;
    dpch_jmp         = jmp;
    dpch_jmp_br_addr = tgt;
  endtask

  initial begin
    rst = 1'b1;
    dpch_rd = 1'b0;
    dpch_jmp = 1'b0;
    dpch_jmp_br_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_rd", {31'd0, imem_rd}, 32'd0);
    chk("rst_imem_addr", imem_addr, RPC);
    chk("rst_empty", {31'd0, ifq_empty}, 32'd1);
    chk("rst_pc", ifq_pc, 32'd0);
    chk("rst_icode", ifq_icode, 32'd0);

    // Fill from reset with no dispatch: four fetches, then stall.
    for (int a = 0; a < 4; a++) exp_req.push_back(RPC + 32'(4 * a));
    repeat (5) drive(1'b0, 1'b0, 1'b0, '0);           // C0..C4

    // Drain at one per cycle while fetch keeps up.
    for (int a = 0; a < 10; a++) exp_dlv.push_back(RPC + 32'(4 * a));
    for (int a = 4; a < 14; a++) exp_req.push_back(RPC + 32'(4 * a));
    drive(1'b0, 1'b1, 1'b0, '0);                      // C5
    @(negedge clk);
    chk("full_empty", {31'd0, ifq_empty}, 32'd0);
    chk("full_pc", ifq_pc, RPC);
    chk("full_icode", ifq_icode, RPC);
    chk("full_no_rd", {31'd0, imem_rd}, 32'd0);
    repeat (9) drive(1'b0, 1'b1, 1'b0, '0);           // C6..C14
    drive(1'b0, 1'b0, 1'b0, '0);                      // C15

    // Redirect with 3 entries + inflight and a simultaneous dispatch read.
    for (int a = 0; a < 4; a++) exp_req.push_back(32'h0040_0100 + 32'(4 * a));
    drive(1'b0, 1'b1, 1'b1, 32'h0040_0100);           // C16
    @(negedge clk);
    chk("jmp_no_rd", {31'd0, imem_rd}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0);                      // C17
    @(negedge clk);
    chk("jmp_n1_empty", {31'd0, ifq_empty}, 32'd1);
    chk("jmp_n1_addr", imem_addr, 32'h0040_0100);
    drive(1'b0, 1'b0, 1'b0, '0);                      // C18
    @(negedge clk);
    chk("jmp_n2_empty", {31'd0, ifq_empty}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0);                      // C19
    @(negedge clk);
    chk("jmp_n3_empty", {31'd0, ifq_empty}, 32'd0);
    chk("jmp_n3_pc", ifq_pc, 32'h0040_0100);
    repeat (2) drive(1'b0, 1'b0, 1'b0, '0);           // C20..C21

    // Back-to-back redirects; reads while empty are ignored.
    for (int a = 0; a < 4; a++) exp_req.push_back(32'h0040_0300 + 32'(4 * a));
    exp_dlv.push_back(32'h0040_0300);
    drive(1'b0, 1'b0, 1'b1, 32'h0040_0200);           // C22
    drive(1'b0, 1'b1, 1'b1, 32'h0040_0300);           // C23
    drive(1'b0, 1'b1, 1'b0, '0);                      // C24
    @(negedge clk);
    chk("bb_empty0", {31'd0, ifq_empty}, 32'd1);
    drive(1'b0, 1'b1, 1'b0, '0);                      // C25
    @(negedge clk);
    chk("bb_empty1", {31'd0, ifq_empty}, 32'd1);
    drive(1'b0, 1'b1, 1'b0, '0);                      // C26
    @(negedge clk);
    chk("bb_head_pc", ifq_pc, 32'h0040_0300);
    drive(1'b0, 1'b0, 1'b0, '0);                      // C27

    // Mid-operation reset: 2 entries queued and a response in flight.
    drive(1'b1, 1'b0, 1'b0, '0);                      // C28
    @(negedge clk);
    chk("mrst_empty", {31'd0, ifq_empty}, 32'd1);
    chk("mrst_imem_rd", {31'd0, imem_rd}, 32'd0);
    chk("mrst_pc", ifq_pc, 32'd0);
    chk("mrst_addr", imem_addr, RPC);
    for (int a = 0; a < 8; a++) exp_req.push_back(RPC + 32'(4 * a));
    for (int a = 0; a < 4; a++) exp_dlv.push_back(RPC + 32'(4 * a));
    repeat (6) drive(1'b0, 1'b1, 1'b0, '0);           // C29..C34
    repeat (4) drive(1'b0, 1'b0, 1'b0, '0);           // C35..C38
    @(negedge clk);
    chk("end_empty", {31'd0, ifq_empty}, 32'd0);
    chk("end_pc", ifq_pc, RPC + 32'h10);
    chk("end_no_rd", {31'd0, imem_rd}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("req_left", 32'(exp_req.size()), 32'd0);
    chk("dlv_left", 32'(exp_dlv.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries (power of two, >=2).
REQ-002 Parameter RESET_PC, default 32'h00400000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 imem_rd  output  1  fetch request to instruction memory this cycle.
REQ-006 imem_addr  output  32  word-aligned fetch address, valid when imem_rd=1.
REQ-007 imem_data  input  32  instruction word; valid in the cycle after the request (fixed 1-cycle latency, no backpressure).
REQ-008 ifq_pc  output  32  PC of head entry.
REQ-009 ifq_icode  output  32  instruction word of head entry.
REQ-010 ifq_empty  output  1  queue holds no valid entry.
REQ-011 dpch_rd  input  1  dispatch consumes the head entry this cycle.
REQ-012 dpch_jmp  input  1  redirect request (jal, jalr or taken branch).
REQ-013 dpch_jmp_br_addr  input  32  redirect target, valid when dpch_jmp=1.

Function
REQ-014 Storage: circular buffer of DEPTH entries {pc[31:0], icode[31:0]}, head/tail pointers wrap modulo DEPTH, occupancy counter 0..DEPTH.
REQ-015 ifq_pc/ifq_icode are combinational reads of the head entry; their value is don't-care for consumers when ifq_empty=1 but SHALL still equal stored contents (no X).
REQ-016 ifq_empty = (count == 0), combinational from registered count.
REQ-017 Fetch PC register fpc drives imem_addr; imem_rd = ~dpch_jmp & ((count + inflight) < DEPTH), where inflight is a 1-bit register set in any cycle imem_rd=1.
REQ-018 On imem_rd=1 without redirect, fpc <= fpc + 4 (32-bit wrap, no carry out).
REQ-019 Response: in the cycle with inflight=1 and dpch_jmp=0, {pc_of_request, imem_data} SHALL be written at tail and count incremented at the clock edge; pc_of_request is held in a register captured at request time.
REQ-020 Pop: dpch_rd=1 with ifq_empty=0 and dpch_jmp=0 advances head and decrements count; dpch_rd with ifq_empty=1 is ignored, no state change.
REQ-021 Simultaneous push and pop in one cycle: both pointers advance, count unchanged.
REQ-022 The credit rule of REQ-017 SHALL guarantee a response never arrives with count == DEPTH; no entry is ever overwritten.
REQ-023 Redirect: dpch_jmp=1 has priority over dpch_rd and any response; at the edge, count<=0, head<=tail, inflight<=0, any response arriving in that cycle is discarded, fpc<=dpch_jmp_br_addr.
REQ-024 Redirect latency: dpch_jmp in cycle N -> imem_rd=1, imem_addr=target in N+1 -> entry written at end of N+2 -> ifq_empty=0, ifq_pc=target in N+3.
REQ-025 A request issued in the cycle before a redirect whose response lands in the redirect cycle is dropped; a request issued in the redirect cycle does not exist (REQ-017).
REQ-026 Back-to-back redirects: each dpch_jmp reloads fpc; only the last target is fetched.
REQ-027 Steady state with continuous dpch_rd and no redirects: one instruction delivered per cycle after the initial fill.

Reset
REQ-028 While rst=1: fpc=RESET_PC, count=0, head=tail=0, inflight=0, all entries cleared to 0, pc_of_request=0.
REQ-029 Outputs during reset: imem_rd=0, imem_addr=RESET_PC, ifq_empty=1, ifq_pc=0, ifq_icode=0.
REQ-030 Reset asserted mid-operation (queue partly full, request in flight) SHALL discard all entries and the in-flight response immediately; first cycle after release issues imem_rd=1 at RESET_PC.

Verification
REQ-031 Release reset, dpch_rd=0, memory returns addr-as-data -> requests 0x00400000..0x0040000C then imem_rd=0; count=4; head pc=0x00400000, icode=0x00400000.
REQ-032 Full queue, dpch_rd=1 every cycle -> one pop per cycle, imem_rd resumes next cycle, ifq_pc sequence 0x00400000,04,08,... with no gap after fill and no lost or duplicated entry.
REQ-033 Queue holding 3 entries plus inflight=1, dpch_jmp=1 with target 0x00400100 and dpch_rd=1 same cycle -> next cycle ifq_empty=1, imem_addr=0x00400100; response in jmp cycle discarded; ifq_pc=0x00400100 three cycles after jmp.
REQ-034 dpch_rd=1 while ifq_empty=1 -> no pointer/count change, ifq_empty stays 1.
REQ-035 dpch_jmp in two consecutive cycles (0x00400200 then 0x00400300) -> no entry at 0x00400200 ever appears; first head pc=0x00400300.
REQ-036 rst pulsed for one cycle with 2 entries queued and a request in flight -> ifq_empty=1 during reset; after release first request at 0x00400000, no stale entry delivered.
